// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI frame to register-bus controller; optional macro SPI_REG_CTRL_AUTOINC_EN
module spi_reg_ctrl #(
  parameter logic [7:0] ID_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss,
  input  logic       spi_done,
  input  logic [7:0] spi_dout,
  output logic [7:0] spi_din,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_ss_s1;
  logic       r_ss_s2;
  logic       r_ss_d;
  logic       w_frame_end;

  logic [6:0] r_addr;
  logic [6:0] w_addr_nxt;
  logic [6:0] w_addr_adv;
  logic [6:0] r_reg_addr;
  logic [6:0] w_reg_addr_nxt;
  logic [7:0] r_wdata;
  logic [7:0] w_wdata_nxt;
  logic       r_we;
  logic       w_we_nxt;
  logic       r_re;
  logic       w_re_nxt;
  logic       r_re_d;
  logic [7:0] r_din;
  logic [7:0] w_din_nxt;

  // Two-flop synchronizer on ss plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_s1 <= 1'b0;
      r_ss_s2 <= 1'b0;
      r_ss_d  <= 1'b0;
    end else begin
      r_ss_s1 <= ss;
      r_ss_s2 <= r_ss_s1;
      r_ss_d  <= r_ss_s2;
    end
  end

  assign w_frame_end = r_ss_s2 & ~r_ss_d;

  // Address step used after each data byte; without auto-increment the frame
  // keeps hitting the command address (FIFO-port style).
`ifdef SPI_REG_CTRL_AUTOINC_EN
  assign w_addr_adv = r_addr + 7'd1;
`else
  assign w_addr_adv = r_addr;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: command byte picks the direction; frame end wins last so a
  // coincident byte is still decoded before returning to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_IDLE) && spi_done) begin
      w_state_nxt = spi_dout[7] ? ST_READ : ST_WRITE;
    end
    if (w_frame_end) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Output/datapath next values: strobes, bus address/data and MISO byte.
  always_comb begin
    w_addr_nxt     = r_addr;
    w_reg_addr_nxt = r_reg_addr;
    w_wdata_nxt    = r_wdata;
    w_we_nxt       = 1'b0;
    w_re_nxt       = 1'b0;
    w_din_nxt      = r_din;
    if (spi_done) begin
      case (r_state)
        ST_IDLE: begin
          w_addr_nxt = spi_dout[6:0];
          if (spi_dout[7]) begin
            w_re_nxt       = 1'b1;
            w_reg_addr_nxt = spi_dout[6:0];
          end
        end
        ST_WRITE: begin
          w_we_nxt       = 1'b1;
          w_reg_addr_nxt = r_addr;
          w_wdata_nxt    = spi_dout;
          w_addr_nxt     = w_addr_adv;
        end
        ST_READ: begin
          w_re_nxt       = 1'b1;
          w_reg_addr_nxt = w_addr_adv;
          w_addr_nxt     = w_addr_adv;
        end
        default: begin
        end
      endcase
    end
    // Read data is only taken while the frame is still alive; a read that
    // straddles the frame end completes on the bus but never reaches MISO.
    if (r_re_d && (r_state == ST_READ) && !w_frame_end) begin
      w_din_nxt = reg_rdata;
    end
    if (w_frame_end) begin
      w_din_nxt = ID_BYTE;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= 7'd0;
      r_reg_addr <= 7'd0;
      r_wdata    <= 8'd0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_re_d     <= 1'b0;
      r_din      <= ID_BYTE;
    end else begin
      r_addr     <= w_addr_nxt;
      r_reg_addr <= w_reg_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_we       <= w_we_nxt;
      r_re       <= w_re_nxt;
      r_re_d     <= r_re;
      r_din      <= w_din_nxt;
    end
  end

  assign spi_din   = r_din;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign active    = (r_state != ST_IDLE);

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-access controller sitting behind `spi_slave`. It turns the slave's received byte stream into single-cycle register-bus reads and writes. It sequences each SPI frame as a command byte followed by data bytes, with address auto-increment, and it supplies the slave's transmit byte for reads. Within the FPGA it is the only master on the 7-bit-address, 8-bit-data configuration register bus.

## Interface
Parameters:
- `ID_BYTE`, 8'hA5, byte returned on MISO for the first two bytes of every frame.

Ports:
- `clk`  in  1  system clock, the same clock as `spi_slave`.
- `rst_n`  in  1  reset, asynchronous and active-low. All flops clear on assertion; release is used synchronously.
- `ss`  in  1  raw SPI slave-select pin, active-low. Synchronized internally.
- `spi_done`  in  1  one-cycle pulse from `spi_slave` when a byte completes.
- `spi_dout`  in  8  received byte, valid with `spi_done`.
- `spi_din`  out  8  transmit byte to `spi_slave` (its `din`). Registered.
- `reg_addr`  out  7  register address.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  write strobe, one cycle.
- `reg_re`  out  1  read strobe, one cycle.
- `reg_rdata`  in  8  read data, valid exactly one cycle after `reg_re`.
- `active`  out  1  high while a frame is in progress (state not IDLE).

## Operation
- `ss` passes through a two-flop synchronizer to produce `ss_s`. The rising edge of `ss_s` is the frame end.
- State machine: IDLE, WRITE, READ.
- **IDLE**:
  - `spi_din` = `ID_BYTE`.
  - On `spi_done`, latch `addr` = `spi_dout[6:0]`.
  - If `spi_dout[7]` = 0, go to WRITE.
  - If `spi_dout[7]` = 1, go to READ and issue `reg_re` at `addr`.
- **WRITE**: on `spi_done`:
  - issue `reg_we` with `reg_addr`=`addr` and `reg_wdata`=`spi_dout`;
  - then advance `addr`.
- **READ**:
  - The cycle after `reg_re`, load `spi_din` <= `reg_rdata`.
  - On each `spi_done`, advance `addr` and issue `reg_re` at the new address.
  - Frame byte k (k≥2) therefore returns reg[A+k-2]. Bytes 0 and 1 return `ID_BYTE`.
- Address advance is `addr+1` modulo 128: 7'h7F wraps to 7'h00. See Configuration.
- The frame end (rising edge of `ss_s`) forces IDLE from any state and sets `spi_din` <= `ID_BYTE`. `addr` is held.
- A `spi_done` coinciding with the frame end is processed first: the write or read strobe still fires, then the state goes to IDLE.
- A read in flight when the frame ends completes on the bus, but its data is discarded (`spi_din` stays `ID_BYTE`).
- Reset values: state IDLE, `addr`=0, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `spi_din`=`ID_BYTE`, `active`=0.
- Asserting `rst_n` mid-frame aborts immediately with no strobe. After release the block sits in IDLE, and the next `spi_done` is treated as a command byte even if the frame continues.

## Timing
- Strobe timing: `reg_we`/`reg_re` assert on the cycle after the triggering `spi_done`, for exactly one cycle.
- `reg_addr` and `reg_wdata` are stable in the strobe cycle.
- Read-to-MISO latency: `spi_din` updates 2 cycles after `spi_done` (strobe cycle + data cycle).
- `spi_slave` samples `din` on its `spi_done` cycle, so consecutive `spi_done` pulses must be ≥4 clk apart. This holds automatically for SCK ≤ clk/4.
- `active` follows the state register. It drops 3 cycles after `ss` rises (2 synchronizer stages + edge detect).
- At most one strobe per cycle; `reg_we` and `reg_re` are never high together.

## Configuration
- `SPI_REG_CTRL_AUTOINC_EN`:
  - **Defined**: `addr` increments (mod 128) after every data-byte write and at every READ-state `spi_done`, as described above.
  - **Not defined**: `addr` stays at the command address for the whole frame. Writes repeatedly target the same register (FIFO-port style). Reads re-issue `reg_re` at the same address, so byte k (k≥2) returns reg[A] sampled at each re-read.

## Test plan
- **Write burst**: frame 8'h10, 8'h11, 8'h22 → `reg_we` at addr 7'h10 data 8'h11, then addr 7'h11 data 8'h22; `active` high, then low 3 cycles after `ss` rises.
- **Read burst**: with reg[5]=8'h3C and reg[6]=8'h4D, frame 8'h85 + 3 dummy bytes → MISO returns 8'hA5, 8'hA5, 8'h3C, 8'h4D.
- **Wrap**: write frame 8'h7F, 8'hAA, 8'hBB → writes at 7'h7F then 7'h00. Without `SPI_REG_CTRL_AUTOINC_EN`, both writes go to 7'h7F.
- **Frame abort**: raise `ss` mid-READ → state IDLE; next frame's first byte is decoded as a command and MISO returns 8'hA5.
- **Simultaneous edge**: `spi_done` on the same cycle as the synchronized `ss` rising edge in WRITE → `reg_we` fires once, then IDLE.
- **Async reset**: pull `rst_n` low mid-READ, asynchronous to `clk` → all outputs reach reset values immediately and no strobe is issued.
